// File: rtl/pipe_hazard_ctrl.sv
// Purpose: D-stage hazard controller (register, mult/div and eret stalls) with exception flush override.
// Latency: all control outputs are combinational from inputs; only the mult/div countdown is registered.
// Backpressure: a hazard holds PC and IF/ID and injects an ID/EX bubble until it clears; Req forces a flush.
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       Req,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic       use_rs_D,
  input  logic       use_rt_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic [4:0] A3_E,
  input  logic [1:0] Tnew_E,
  input  logic [4:0] A3_M,
  input  logic [1:0] Tnew_M,
  input  logic       md_use_D,
  input  logic       md_start_E,
  input  logic       md_div_E,
  input  logic       eret_D,
  input  logic       mtc0_epc_E,
  input  logic       mtc0_epc_M,
  output logic       PC_en,
  output logic       IF_ID_en,
  output logic       ID_EX_clr,
  output logic       md_busy,
  output logic       stall
);

  // Cycles the mult/div unit stays occupied after the start cycle.
  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  logic [3:0] md_cnt;
  logic [3:0] md_cnt_nxt;
  logic       md_start_ok;

  logic       rs_hit_e;
  logic       rs_hit_m;
  logic       rt_hit_e;
  logic       rt_hit_m;
  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;
  logic       stall_eret;
  logic       stall_any;

  // A source operand conflicts with a producer stage when the addresses match,
  // the producer actually writes a real register (not $0), and the result
  // arrives later than the consumer needs it. Widths are 2-bit unsigned.
  always_comb begin
    rs_hit_e = (rs_D == A3_E) && (A3_E != 5'd0) && (Tuse_rs_D < Tnew_E);
    rs_hit_m = (rs_D == A3_M) && (A3_M != 5'd0) && (Tuse_rs_D < Tnew_M);
    rt_hit_e = (rt_D == A3_E) && (A3_E != 5'd0) && (Tuse_rt_D < Tnew_E);
    rt_hit_m = (rt_D == A3_M) && (A3_M != 5'd0) && (Tuse_rt_D < Tnew_M);
  end

  // Register hazards only matter for operands the D instruction really reads.
  always_comb begin
    stall_rs = use_rs_D && (rs_D != 5'd0) && (rs_hit_e || rs_hit_m);
    stall_rt = use_rt_D && (rt_D != 5'd0) && (rt_hit_e || rt_hit_m);
  end

  // A start presented alongside an exception belongs to a flushed instruction,
  // so it neither loads the counter nor makes the unit look busy.
  always_comb begin
    md_start_ok = md_start_E && !Req;
    md_busy     = md_start_ok || (md_cnt != 4'd0);
    stall_md    = md_use_D && md_busy;
  end

  // eret must not read EPC while an mtc0 to EPC is still in flight in E or M.
  always_comb begin
    stall_eret = eret_D && (mtc0_epc_E || mtc0_epc_M);
    stall_any  = stall_rs || stall_rt || stall_md || stall_eret;
  end

  // Counter next state: a new start always reloads (last start wins), otherwise
  // count down to zero and hold. An in-flight count keeps running through Req.
  always_comb begin
    md_cnt_nxt = md_cnt;
    if (md_start_ok) begin
      md_cnt_nxt = md_div_E ? DIV_CYCLES : MULT_CYCLES;
    end else if (md_cnt != 4'd0) begin
      md_cnt_nxt = md_cnt - 4'd1;
    end
  end

  // Mult/div occupancy counter; reset aborts any count immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= 4'd0;
    end else begin
      md_cnt <= md_cnt_nxt;
    end
  end

  // Pipeline enables: an exception flushes and redirects regardless of hazards,
  // otherwise a hazard freezes PC and IF/ID and bubbles ID/EX.
  always_comb begin
    PC_en     = 1'b1;
    IF_ID_en  = 1'b1;
    ID_EX_clr = 1'b0;
    stall     = 1'b0;
    if (Req) begin
      ID_EX_clr = 1'b1;
    end else if (stall_any) begin
      PC_en     = 1'b0;
      IF_ID_en  = 1'b0;
      ID_EX_clr = 1'b1;
      stall     = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: directed scoreboard bench for pipe_hazard_ctrl.
// Latency: one vector per clock; outputs sampled on the falling edge.
// Backpressure: none; stimulus pushes expectations, monitor pops one per cycle.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       Req;
  logic [4:0] rs_D, rt_D, A3_E, A3_M;
  logic       use_rs_D, use_rt_D;
  logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
  logic       md_use_D, md_start_E, md_div_E, eret_D, mtc0_epc_E, mtc0_epc_M;
  logic       PC_en, IF_ID_en, ID_EX_clr, md_busy, stall;

  typedef struct packed {
    logic       rst;
    logic       req;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [1:0] tus;
    logic [1:0] tut;
    logic [4:0] a3e;
    logic [1:0] tne;
    logic [4:0] a3m;
    logic [1:0] tnm;
    logic       mduse;
    logic       mdstart;
    logic       mddiv;
    logic       eret;
    logic       epce;
    logic       epcm;
  } in_t;

  typedef struct {
    string      name;
    logic       pc;
    logic       ifid;
    logic       clr;
    logic       busy;
    logic       stl;
    logic       chk_cnt;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .Req(Req),
    .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
    .A3_E(A3_E), .Tnew_E(Tnew_E), .A3_M(A3_M), .Tnew_M(Tnew_M),
    .md_use_D(md_use_D), .md_start_E(md_start_E), .md_div_E(md_div_E),
    .eret_D(eret_D), .mtc0_epc_E(mtc0_epc_E), .mtc0_epc_M(mtc0_epc_M),
    .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_EX_clr(ID_EX_clr),
    .md_busy(md_busy), .stall(stall)
  );

  always #5 clk = ~clk;

  // Normal mode expectation: stall s, busy b, optional counter check.
  function automatic exp_t ex(string n, logic s, logic b, logic cc, logic [3:0] c);
    exp_t e;
    e.name = n; e.pc = ~s; e.ifid = ~s; e.clr = s; e.busy = b; e.stl = s;
    e.chk_cnt = cc; e.cnt = c;
    return e;
  endfunction

  // Exception flush expectation.
  function automatic exp_t exr(string n, logic b, logic cc, logic [3:0] c);
    exp_t e;
    e.name = n; e.pc = 1'b1; e.ifid = 1'b1; e.clr = 1'b1; e.busy = b; e.stl = 1'b0;
    e.chk_cnt = cc; e.cnt = c;
    return e;
  endfunction

  task automatic set_inputs(input in_t v);
    reset = v.rst; Req = v.req; rs_D = v.rs; rt_D = v.rt;
    use_rs_D = v.urs; use_rt_D = v.urt; Tuse_rs_D = v.tus; Tuse_rt_D = v.tut;
    A3_E = v.a3e; Tnew_E = v.tne; A3_M = v.a3m; Tnew_M = v.tnm;
    md_use_D = v.mduse; md_start_E = v.mdstart; md_div_E = v.mddiv;
    eret_D = v.eret; mtc0_epc_E = v.epce; mtc0_epc_M = v.epcm;
  endtask

  task automatic drive(input in_t v, input exp_t e);
    @(posedge clk);
    #1;
    set_inputs(v);
    q.push_back(e);
  endtask

  // Monitor: one expectation per falling edge, compared against live outputs.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      vectors++;
      if ({PC_en, IF_ID_en, ID_EX_clr, md_busy, stall} !==
          {mon_e.pc, mon_e.ifid, mon_e.clr, mon_e.busy, mon_e.stl} ||
          (mon_e.chk_cnt && dut.md_cnt !== mon_e.cnt)) begin
        miscompares++;
        $display("FAIL %s: got pc/ifid/clr/busy/stall=%b%b%b%b%b cnt=%0d, want %b%b%b%b%b cnt=%0d",
                 mon_e.name, PC_en, IF_ID_en, ID_EX_clr, md_busy, stall, dut.md_cnt,
                 mon_e.pc, mon_e.ifid, mon_e.clr, mon_e.busy, mon_e.stl, mon_e.cnt);
      end
    end
  end

  initial begin
    in_t v;
    v = '0;
    v.rst = 1'b1;
    set_inputs(v);

    // Reset state
    drive(v, ex("reset_idle", 1'b0, 1'b0, 1'b1, 4'd0));
    v.rst = 1'b0;
    drive(v, ex("idle", 1'b0, 1'b0, 1'b1, 4'd0));

    // Load-use on rs: E producer, then M producer, then ready
    v = '0; v.urs = 1; v.rs = 5'd8; v.tus = 2'd0; v.a3e = 5'd8; v.tne = 2'd2;
    drive(v, ex("loaduse_E", 1'b1, 1'b0, 1'b0, 4'd0));
    v.a3e = 5'd0; v.tne = 2'd0; v.a3m = 5'd8; v.tnm = 2'd1;
    drive(v, ex("loaduse_M", 1'b1, 1'b0, 1'b0, 4'd0));
    v.tnm = 2'd0;
    drive(v, ex("loaduse_M_ready", 1'b0, 1'b0, 1'b0, 4'd0));

    // $0 target never stalls
    v = '0; v.urs = 1; v.rs = 5'd0; v.tus = 2'd0; v.a3e = 5'd0; v.tne = 2'd2;
    drive(v, ex("zero_reg", 1'b0, 1'b0, 1'b0, 4'd0));

    // rt path and Tuse/Tnew boundaries
    v = '0; v.urt = 1; v.rt = 5'd5; v.tut = 2'd1; v.a3e = 5'd5; v.tne = 2'd2;
    drive(v, ex("rt_1lt2", 1'b1, 1'b0, 1'b0, 4'd0));
    v.tut = 2'd2;
    drive(v, ex("rt_2eq2", 1'b0, 1'b0, 1'b0, 4'd0));
    v.tut = 2'd1; v.tne = 2'd1;
    drive(v, ex("rt_1eq1", 1'b0, 1'b0, 1'b0, 4'd0));
    v.tne = 2'd2; v.urt = 0;
    drive(v, ex("rt_unused", 1'b0, 1'b0, 1'b0, 4'd0));
    v = '0; v.urt = 1; v.rt = 5'd9; v.tut = 2'd0; v.a3e = 5'd3; v.tne = 2'd2; v.a3m = 5'd9; v.tnm = 2'd1;
    drive(v, ex("rt_M_only", 1'b1, 1'b0, 1'b0, 4'd0));

    // Eret hazard
    v = '0; v.eret = 1; v.epcm = 1;
    drive(v, ex("eret_M", 1'b1, 1'b0, 1'b0, 4'd0));
    v.epcm = 0;
    drive(v, ex("eret_clear", 1'b0, 1'b0, 1'b0, 4'd0));
    v.epce = 1;
    drive(v, ex("eret_E", 1'b1, 1'b0, 1'b0, 4'd0));

    // Req overrides a load-use stall
    v = '0; v.urs = 1; v.rs = 5'd8; v.a3e = 5'd8; v.tne = 2'd2; v.req = 1;
    drive(v, exr("req_over_stall", 1'b0, 1'b0, 4'd0));
    // Req with a start: ignored
    v = '0; v.req = 1; v.mdstart = 1; v.mddiv = 1; v.mduse = 1;
    drive(v, exr("req_start", 1'b0, 1'b1, 4'd0));
    v = '0; v.mduse = 1;
    drive(v, ex("req_start_noload", 1'b0, 1'b0, 1'b1, 4'd0));

    // Divide then mfhi: 11 stalled cycles, released on the 12th
    v = '0; v.mdstart = 1; v.mddiv = 1; v.mduse = 1;
    drive(v, ex("div_start", 1'b1, 1'b1, 1'b1, 4'd0));
    v = '0; v.mduse = 1;
    for (int i = 1; i < 12; i++) begin
      drive(v, ex($sformatf("div_c%0d", i), i < 11, i < 11, 1'b1, 4'(11 - i)));
    end

    // Multiply then mflo: 6 stalled cycles, released on the 7th
    v = '0; v.mdstart = 1; v.mddiv = 0; v.mduse = 1;
    drive(v, ex("mult_start", 1'b1, 1'b1, 1'b1, 4'd0));
    v = '0; v.mduse = 1;
    for (int i = 1; i < 7; i++) begin
      drive(v, ex($sformatf("mult_c%0d", i), i < 6, i < 6, 1'b1, 4'(6 - i)));
    end

    // Count continues through Req; last start wins
    v = '0; v.mdstart = 1;
    drive(v, ex("mult_start2", 1'b0, 1'b1, 1'b1, 4'd0));
    v = '0; v.req = 1; v.mduse = 1;
    drive(v, exr("req_mid_count", 1'b1, 1'b1, 4'd5));
    v = '0;
    drive(v, ex("after_req", 1'b0, 1'b1, 1'b1, 4'd4));
    v.mdstart = 1; v.mddiv = 1;
    drive(v, ex("restart_div", 1'b0, 1'b1, 1'b1, 4'd3));
    v = '0;
    drive(v, ex("div_reloaded", 1'b0, 1'b1, 1'b1, 4'd10));
    v.mdstart = 1; v.mddiv = 0;
    drive(v, ex("restart_mult", 1'b0, 1'b1, 1'b1, 4'd9));
    v = '0;
    drive(v, ex("mult_reloaded", 1'b0, 1'b1, 1'b1, 4'd5));
    for (int i = 0; i < 5; i++) begin
      drive(v, ex($sformatf("drain_%0d", i), 1'b0, i < 4, 1'b1, 4'(4 - i)));
    end

    // Async reset mid-divide at md_cnt = 7
    v = '0; v.mdstart = 1; v.mddiv = 1; v.mduse = 1;
    drive(v, ex("rdiv_start", 1'b1, 1'b1, 1'b1, 4'd0));
    v = '0; v.mduse = 1;
    for (int i = 1; i < 4; i++) begin
      drive(v, ex($sformatf("rdiv_c%0d", i), 1'b1, 1'b1, 1'b1, 4'(11 - i)));
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    q.push_back(ex("rdiv_reset", 1'b0, 1'b0, 1'b1, 4'd0));
    drive(v, ex("rdiv_after", 1'b0, 1'b0, 1'b1, 4'd0));

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
